// File: rtl/fma_pkg.sv
// Shared types and defaults for the fixed-point FMA lane and its upstream sequencer.
package fma_pkg;

  localparam int WIDTH_DEF       = 16;
  localparam int FIXED_POINT_DEF = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    WAIT   = 2'd2,
    RESULT = 2'd3
  } seq_state_t;

  // FMA operand bus order is {a, b, c}, a in the most significant slice.
  function automatic logic [3*WIDTH_DEF-1:0] pack_abc(
    input logic [WIDTH_DEF-1:0] a,
    input logic [WIDTH_DEF-1:0] b,
    input logic [WIDTH_DEF-1:0] c
  );
    return {a, b, c};
  endfunction

endpackage

// File: rtl/fma_dot_sequencer.sv
// Turns a dot-product job (bias, N, N a/b pairs) into the FMA control stream and
// holds the final accumulator value on a ready/valid result port.
//
// state  | meaning
// IDLE   | ready for a job descriptor
// ACCUM  | issuing a/b pairs to the FMA, one per accepted handshake
// WAIT   | last pair issued, waiting for the FMA result
// RESULT | result held until downstream accepts it
module fma_dot_sequencer
  import fma_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int FIXED_POINT = FIXED_POINT_DEF,
  parameter int LEN_WIDTH   = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 job_valid_in,
  output logic                 job_ready_out,
  input  logic [LEN_WIDTH-1:0] job_len_in,
  input  logic [WIDTH-1:0]     job_bias_in,
  input  logic                 ab_valid_in,
  output logic                 ab_ready_out,
  input  logic [2*WIDTH-1:0]   ab_in,
  output logic [3*WIDTH-1:0]   fma_abc_out,
  output logic                 fma_valid_out,
  output logic                 fma_c_valid_out,
  output logic                 fma_out_can_be_valid_out,
  input  logic [WIDTH-1:0]     fma_result_in,
  input  logic                 fma_result_valid_in,
  output logic [WIDTH-1:0]     result_out,
  output logic                 result_valid_out,
  input  logic                 result_ready_in,
  output logic                 busy_out,
  output logic                 protocol_err_out
);

  if (FIXED_POINT > WIDTH) begin : g_bad_fixed_point
    $error("FIXED_POINT must not exceed WIDTH");
  end

  seq_state_t           state;
  logic [LEN_WIDTH-1:0] remaining;
  logic [WIDTH-1:0]     bias;
  logic                 first;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                    <= IDLE;
      remaining                <= '0;
      bias                     <= '0;
      first                    <= 1'b0;
      job_ready_out            <= 1'b0;
      ab_ready_out             <= 1'b0;
      fma_abc_out              <= '0;
      fma_valid_out            <= 1'b0;
      fma_c_valid_out          <= 1'b0;
      fma_out_can_be_valid_out <= 1'b0;
      result_out               <= '0;
      result_valid_out         <= 1'b0;
      busy_out                 <= 1'b0;
      protocol_err_out         <= 1'b0;
    end else begin
      // Issue slot is a one-cycle pulse; the bus returns to zero between issues.
      fma_valid_out            <= 1'b0;
      fma_abc_out              <= '0;
      fma_c_valid_out          <= 1'b0;
      fma_out_can_be_valid_out <= 1'b0;

      if (fma_result_valid_in && state != WAIT) begin
        protocol_err_out <= 1'b1;
      end

      case (state)
        IDLE: begin
          job_ready_out <= 1'b1;
          if (job_valid_in && job_ready_out) begin
            remaining     <= job_len_in;
            bias          <= job_bias_in;
            first         <= 1'b1;
            job_ready_out <= 1'b0;
            busy_out      <= 1'b1;
            if (job_len_in == '0) begin
              result_out       <= job_bias_in;
              result_valid_out <= 1'b1;
              state            <= RESULT;
            end else begin
              ab_ready_out <= 1'b1;
              state        <= ACCUM;
            end
          end
        end

        ACCUM: begin
          if (ab_valid_in && ab_ready_out) begin
            fma_valid_out            <= 1'b1;
            fma_abc_out              <= pack_abc(ab_in[2*WIDTH-1:WIDTH], ab_in[WIDTH-1:0],
                                                 first ? bias : '0);
            fma_c_valid_out          <= first;
            fma_out_can_be_valid_out <= (remaining == LEN_WIDTH'(1));
            first                    <= 1'b0;
            remaining                <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              ab_ready_out <= 1'b0;
              state        <= WAIT;
            end
          end
        end

        WAIT: begin
          if (fma_result_valid_in) begin
            result_out       <= fma_result_in;
            result_valid_out <= 1'b1;
            state            <= RESULT;
          end
        end

        RESULT: begin
          if (result_ready_in) begin
            result_valid_out <= 1'b0;
            busy_out         <= 1'b0;
            job_ready_out    <= 1'b1;
            state            <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fma_dot_sequencer.sv
// Directed bench: sequencer driving a single-cycle behavioural FMA lane model.
module tb_fma_dot_sequencer;
  import fma_pkg::*;

  localparam int W  = 16;
  localparam int LW = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          job_valid_in;
  logic          job_ready_out;
  logic [LW-1:0] job_len_in;
  logic [W-1:0]  job_bias_in;
  logic          ab_valid_in;
  logic          ab_ready_out;
  logic [2*W-1:0] ab_in;
  logic [3*W-1:0] fma_abc_out;
  logic          fma_valid_out;
  logic          fma_c_valid_out;
  logic          fma_out_can_be_valid_out;
  logic [W-1:0]  fma_result_in;
  logic          fma_result_valid_in;
  logic [W-1:0]  result_out;
  logic          result_valid_out;
  logic          result_ready_in;
  logic          busy_out;
  logic          protocol_err_out;

  logic          model_valid;
  logic [W-1:0]  model_acc;
  logic          inject_valid;

  int checks = 0;
  int errors = 0;
  int issue_cnt = 0;
  logic [2*W-1:0] pairs [8];

  always #5 clk_in = ~clk_in;

  fma_dot_sequencer #(.WIDTH(W), .FIXED_POINT(10), .LEN_WIDTH(LW)) dut (
    .clk_in                   (clk_in),
    .rst_in                   (rst_in),
    .job_valid_in             (job_valid_in),
    .job_ready_out            (job_ready_out),
    .job_len_in               (job_len_in),
    .job_bias_in              (job_bias_in),
    .ab_valid_in              (ab_valid_in),
    .ab_ready_out             (ab_ready_out),
    .ab_in                    (ab_in),
    .fma_abc_out              (fma_abc_out),
    .fma_valid_out            (fma_valid_out),
    .fma_c_valid_out          (fma_c_valid_out),
    .fma_out_can_be_valid_out (fma_out_can_be_valid_out),
    .fma_result_in            (fma_result_in),
    .fma_result_valid_in      (fma_result_valid_in),
    .result_out               (result_out),
    .result_valid_out         (result_valid_out),
    .result_ready_in          (result_ready_in),
    .busy_out                 (busy_out),
    .protocol_err_out         (protocol_err_out)
  );

  // Q6.10 multiply-accumulate: acc' = (c_valid ? c : acc) + (a*b >>> 10).
  function automatic logic [W-1:0] fma_step(input logic [W-1:0] acc, input logic [3*W-1:0] abc,
                                            input logic c_valid);
    logic signed [2*W-1:0] prod;
    logic [W-1:0] base;
    prod = $signed(abc[3*W-1:2*W]) * $signed(abc[2*W-1:W]);
    base = c_valid ? abc[W-1:0] : acc;
    return base + W'(prod >>> 10);
  endfunction

  logic [W-1:0] model_out;
  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      model_acc   <= '0;
      model_valid <= 1'b0;
      model_out   <= '0;
    end else begin
      model_valid <= 1'b0;
      if (fma_valid_out) begin
        model_acc <= fma_step(model_acc, fma_abc_out, fma_c_valid_out);
        if (fma_out_can_be_valid_out) begin
          model_valid <= 1'b1;
          model_out   <= fma_step(model_acc, fma_abc_out, fma_c_valid_out);
        end
      end
    end
  end

  assign fma_result_in       = model_out;
  assign fma_result_valid_in = model_valid | inject_valid;

  always @(negedge clk_in) if (fma_valid_out) issue_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             {job_ready_out, ab_ready_out, fma_valid_out, fma_c_valid_out,
              fma_out_can_be_valid_out, result_valid_out, busy_out, protocol_err_out}, 0);
    check_eq({tag, "_abc"}, fma_abc_out, 0);
    check_eq({tag, "_res"}, result_out, 0);
  endtask

  // Runs a job from descriptor to a visible result; leaves the result unconsumed.
  task automatic do_job(input string tag, input logic [W-1:0] bias, input int n, input int gap,
                        input logic [W-1:0] exp_res);
    int cnt;
    int start_issues;
    cnt = 0;
    while (!job_ready_out && cnt < 20) begin tick(); cnt++; end
    check_eq({tag, "_job_ready"}, job_ready_out, 1);
    job_valid_in = 1'b1;
    job_len_in   = LW'(n);
    job_bias_in  = bias;
    tick();
    job_valid_in = 1'b0;
    start_issues = issue_cnt;
    if (n == 0) begin
      check_eq({tag, "_n0_valid"}, result_valid_out, 1);
      check_eq({tag, "_n0_res"}, result_out, exp_res);
      tick();
      check_eq({tag, "_n0_no_issue"}, 64'(issue_cnt - start_issues), 0);
    end else begin
      for (int i = 0; i < n; i++) begin
        for (int g = 0; g < gap; g++) begin
          ab_valid_in = 1'b0;
          tick();
          check_eq({tag, "_gap_no_issue"}, fma_valid_out, 0);
        end
        ab_valid_in = 1'b1;
        ab_in       = pairs[i];
        check_eq({tag, "_ab_ready"}, ab_ready_out, 1);
        tick();
        ab_valid_in = 1'b0;
        check_eq({tag, "_issue_valid"}, fma_valid_out, 1);
        check_eq({tag, "_issue_abc"}, fma_abc_out,
                 {pairs[i], (i == 0) ? bias : 16'h0000});
        check_eq({tag, "_issue_cv"}, fma_c_valid_out, (i == 0));
        check_eq({tag, "_issue_ocbv"}, fma_out_can_be_valid_out, (i == n - 1));
      end
      check_eq({tag, "_ab_ready_drop"}, ab_ready_out, 0);
      cnt = 1;
      while (!result_valid_out && cnt < 12) begin tick(); cnt++; end
      check_eq({tag, "_latency"}, cnt, 3);
      check_eq({tag, "_res"}, result_out, exp_res);
    end
  endtask

  task automatic consume(input string tag);
    result_ready_in = 1'b1;
    tick();
    result_ready_in = 1'b0;
    check_eq({tag, "_valid_drop"}, result_valid_out, 0);
  endtask

  initial begin
    int start_issues;
    rst_in = 1'b1;
    job_valid_in = 1'b0; job_len_in = '0; job_bias_in = '0;
    ab_valid_in = 1'b0; ab_in = '0; result_ready_in = 1'b0; inject_valid = 1'b0;
    #12;
    check_all_zero("reset");
    rst_in = 1'b0;
    tick();

    // Q6.10 basic: 1.0 + 2*1 + 1*1 + (-1)*2 = 2.0
    pairs[0] = 32'h0800_0400; pairs[1] = 32'h0400_0400; pairs[2] = 32'hFC00_0800;
    do_job("basic", 16'h0400, 3, 0, 16'h0800);
    consume("basic");

    do_job("n0", 16'hF800, 0, 0, 16'hF800);
    consume("n0");

    // N=1 with a 4-cycle operand gap: 0 + 3.0*0.5 = 1.5
    pairs[0] = 32'h0C00_0200;
    do_job("n1gap", 16'h0000, 1, 4, 16'h0600);

    // Backpressure: next job waits behind the held result.
    job_valid_in = 1'b1; job_len_in = 8'd1; job_bias_in = 16'h0400;
    start_issues = issue_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_hold", {job_ready_out, result_valid_out, result_out}, {1'b0, 1'b1, 16'h0600});
    end
    check_eq("bp_no_issue", 64'(issue_cnt - start_issues), 0);
    consume("bp");
    pairs[0] = 32'h0400_0400;
    do_job("bp_next", 16'h0400, 1, 0, 16'h0800);
    consume("bp_next");

    // Async reset between edges after 2 of 5 pairs.
    job_valid_in = 1'b1; job_len_in = 8'd5; job_bias_in = 16'h0400;
    tick();
    job_valid_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ab_valid_in = 1'b1; ab_in = 32'h0400_0400;
      tick();
    end
    ab_valid_in = 1'b0;
    #2 rst_in = 1'b1;
    #1 check_all_zero("midreset");
    #1 rst_in = 1'b0;
    tick();
    pairs[0] = 32'h0400_0400;
    do_job("postreset", 16'h0400, 1, 0, 16'h0800);
    consume("postreset");

    // Unexpected FMA result while idle.
    tick();
    inject_valid = 1'b1;
    tick();
    inject_valid = 1'b0;
    check_eq("perr_set", protocol_err_out, 1);
    tick(); tick();
    check_eq("perr_sticky", {protocol_err_out, busy_out, job_ready_out}, {1'b1, 1'b0, 1'b1});
    pairs[0] = 32'h0400_0400;
    do_job("perr_job", 16'h0200, 1, 0, 16'h0600);
    consume("perr_job");
    check_eq("perr_still", protocol_err_out, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
